// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store memory access unit.
package mem_access_pkg;

    localparam int WORD_W = 32;
    localparam int HALF_W = 16;
    localparam int BYTE_W = 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        RESP
    } state_e;

    // Size code 11 behaves as a word access.
    function automatic logic is_word(input logic [1:0] sz);
        return sz[1];
    endfunction

endpackage

// File: rtl/load_align.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
module load_align
    import mem_access_pkg::*;
(
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [1:0]        offset,
    input  logic [WORD_W-1:0] rword,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] store_word
);

    logic [4:0]        bshift;
    logic [4:0]        hshift;
    logic [BYTE_W-1:0] bval;
    logic [HALF_W-1:0] hval;

    always_comb begin
        bshift     = {offset, 3'b000};
        hshift     = {offset[1], 4'b0000};
        bval       = rword[bshift +: BYTE_W];
        hval       = rword[hshift +: HALF_W];
        load_data  = rword;
        store_word = wdata;
        unique case (1'b1)
            size == SZ_BYTE: begin
                load_data  = {{(WORD_W-BYTE_W){sign_ext & bval[BYTE_W-1]}}, bval};
                store_word = (rword & ~(WORD_W'(8'hFF) << bshift))
                           | (WORD_W'(wdata[BYTE_W-1:0]) << bshift);
            end
            size == SZ_HALF: begin
                load_data  = {{(WORD_W-HALF_W){sign_ext & hval[HALF_W-1]}}, hval};
                store_word = (rword & ~(WORD_W'(16'hFFFF) << hshift))
                           | (WORD_W'(wdata[HALF_W-1:0]) << hshift);
            end
            default: begin
                load_data  = rword;
                store_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit against a registered-read word memory.
// Define MISALIGN_TRAP_EN to fault misaligned accesses instead of force-aligning.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_e            state;
    logic              wr_q;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic [1:0]        off_q;
    logic [DATA_W-1:0] wdata_q;
    logic              fault_q;
    logic              misaligned;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_word;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = (req_size == SZ_HALF && req_addr[0])
                      || (is_word(req_size) && req_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign resp_fault = fault_q;

    load_align u_align (
        .size       (size_q),
        .sign_ext   (sgn_q),
        .offset     (off_q),
        .rword      (mem_read_data),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            req_ready        <= 1'b0;
            resp_valid       <= 1'b0;
            fault_q          <= 1'b0;
            mem_write_enable <= 1'b0;
            resp_rdata       <= '0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            wr_q             <= 1'b0;
            size_q           <= SZ_BYTE;
            sgn_q            <= 1'b0;
            off_q            <= 2'b00;
            wdata_q          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_ready && req_valid) begin
                        req_ready <= 1'b0;
                        wr_q      <= req_write;
                        size_q    <= req_size;
                        sgn_q     <= req_signed;
                        off_q     <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        if (misaligned) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            fault_q    <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            mem_address <= req_addr >> 2;
                            // Full-word stores skip the read.
                            if (req_write && is_word(req_size)) begin
                                state            <= WR;
                                mem_write_enable <= 1'b1;
                                mem_write_data   <= req_wdata;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    if (wr_q) begin
                        state            <= WR;
                        mem_write_enable <= 1'b1;
                        mem_write_data   <= store_word;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                    end
                end
                WR: begin
                    state            <= RESP;
                    mem_write_enable <= 1'b0;
                    resp_valid       <= 1'b1;
                    resp_rdata       <= '0;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    fault_q    <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a byte-array reference memory.
module tb_mem_access_unit;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_signed       (req_signed),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_fault       (resp_fault),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Environment memory (64 words) and reference byte image
    logic [31:0] mem [64];
    logic [7:0]  ref_b [256];
    logic        init_mem;
    int          we_cnt;
    logic [31:0] last_wd;
    logic        addr_oob;

    int n_cmp;
    int n_bad;

    always @(posedge clock) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++)
                mem[i] <= {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]};
            we_cnt   <= 0;
            addr_oob <= 1'b0;
        end else begin
            if (mem_write_enable) begin
                mem[mem_address[5:0]] <= mem_write_data;
                we_cnt  <= we_cnt + 1;
                last_wd <= mem_write_data;
            end
            if (mem_address[31:6] != 26'd0)
                addr_oob <= 1'b1;
        end
        mem_read_data <= mem[mem_address[5:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int i);
        return {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]};
    endfunction

    function automatic logic ref_mis(input logic [1:0] sz, input int a);
`ifdef MISALIGN_TRAP_EN
        if (sz == 2'b01) return (a % 2) != 0;
        if (sz[1]) return (a % 4) != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input int a);
        logic [31:0] v;
        int b;
        if (sz == 2'b00) begin
            v = {24'h0, ref_b[a]};
            if (sg && v[7]) v[31:8] = '1;
        end else if (sz == 2'b01) begin
            b = a - (a % 2);
            v = {16'h0, ref_b[b+1], ref_b[b]};
            if (sg && v[15]) v[31:16] = '1;
        end else begin
            b = a - (a % 4);
            v = ref_word(b / 4);
        end
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input int a, input logic [31:0] wd);
        int b;
        if (sz == 2'b00) begin
            ref_b[a] = wd[7:0];
        end else if (sz == 2'b01) begin
            b = a - (a % 2);
            ref_b[b]   = wd[7:0];
            ref_b[b+1] = wd[15:8];
        end else begin
            b = a - (a % 4);
            for (int k = 0; k < 4; k++) ref_b[b+k] = 8'(wd >> (8*k));
        end
    endtask

    task automatic xfer(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic flt,
                        output int lat, output int wes);
        int n;
        int w0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("ready_wait", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        w0 = we_cnt;
        @(negedge clock);
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        lat = 1;
        while (!resp_valid && lat < 12) begin
            @(negedge clock);
            lat++;
        end
        rd  = resp_rdata;
        flt = resp_fault;
        if (!resp_valid) lat = -1;
        @(negedge clock);
        wes = we_cnt - w0;
    endtask

    task automatic op(input string tag, input logic w, input logic [1:0] sz,
                      input logic sg, input int a, input logic [31:0] wd,
                      output logic [31:0] rd);
        logic        f;
        logic        mis;
        logic [31:0] er;
        int          lat;
        int          wes;
        int          el;
        int          ew;
        mis = ref_mis(sz, a);
        er  = (w || mis) ? 32'd0 : ref_load(sz, sg, a);
        el  = mis ? 1 : (!w ? 3 : (sz[1] ? 2 : 4));
        ew  = (w && !mis) ? 1 : 0;
        xfer(w, sz, sg, 32'(a), wd, rd, f, lat, wes);
        chk({tag, ".rdata"}, rd, er);
        chk({tag, ".fault"}, 32'(f), 32'(mis));
        chk({tag, ".latency"}, lat, el);
        chk({tag, ".we_pulses"}, wes, ew);
        if (w && !mis) ref_store(sz, a, wd);
    endtask

    logic [31:0] rd;
    logic [31:0] x;
    int          w0;
    int          t;
    int          acc;
    int          rcnt;
    int          t_resp1;
    int          t_acc2;
    logic [31:0] rq [$];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 256; i++) ref_b[i] = 8'($urandom);
        {ref_b[7], ref_b[6], ref_b[5], ref_b[4]}     = 32'h00010100;
        {ref_b[27], ref_b[26], ref_b[25], ref_b[24]} = 32'h00000011;
        init_mem   = 1'b1;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        repeat (3) @(negedge clock);
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_fault", 32'(resp_fault), 32'd0);
        chk("rst.mem_we", 32'(mem_write_enable), 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.mem_address", mem_address, 32'd0);
        chk("rst.mem_wdata", mem_write_data, 32'd0);
        init_mem = 1'b0;
        reset    = 1'b0;
        @(negedge clock);
        chk("rst.ready_after", 32'(req_ready), 32'd1);

        op("lw4", 1'b0, 2'b10, 1'b0, 4, 32'd0, rd);
        chk("lw4.value", rd, 32'h00010100);

        op("sw8", 1'b1, 2'b10, 1'b0, 8, 32'hDEADBEEF, rd);
        op("lbB", 1'b0, 2'b00, 1'b1, 11, 32'd0, rd);
        chk("lbB.value", rd, 32'hFFFFFFDE);
        op("lbuB", 1'b0, 2'b00, 1'b0, 11, 32'd0, rd);
        chk("lbuB.value", rd, 32'h000000DE);
        op("lhA", 1'b0, 2'b01, 1'b1, 10, 32'd0, rd);
        chk("lhA.value", rd, 32'hFFFFDEAD);

        op("sb19", 1'b1, 2'b00, 1'b0, 25, 32'h0000005A, rd);
        chk("sb19.wdata", last_wd, 32'h00005A11);
        chk("sb19.mem6", mem[6], 32'h00005A11);
        op("lw18", 1'b0, 2'b10, 1'b0, 24, 32'd0, rd);
        chk("lw18.value", rd, 32'h00005A11);

        op("lh3", 1'b0, 2'b01, 1'b0, 3, 32'd0, rd);
`ifdef MISALIGN_TRAP_EN
        chk("lh3.trap_rdata", rd, 32'd0);
`else
        chk("lh3.aligned", rd, {16'h0, ref_b[3], ref_b[2]});
`endif

        // Reset while an sb sits in CAP
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h21;
        req_wdata  = 32'h77;
        w0 = we_cnt;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort.ready_low", 32'(req_ready), 32'd0);
        @(negedge clock);
        chk("abort.ready_high", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clock);
        chk("abort.no_we", we_cnt - w0, 32'd0);
        chk("abort.word8", mem[8], ref_word(8));

        // Back-to-back with req_valid held high: sw then lw to the same word
        x          = $urandom;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 32'h40;
        req_wdata  = x;
        w0 = we_cnt;
        t = 0;
        acc = 0;
        rcnt = 0;
        t_resp1 = -1;
        t_acc2 = -2;
        rq.delete();
        repeat (20) begin
            if (resp_valid) begin
                rcnt++;
                rq.push_back(resp_rdata);
                if (rcnt == 1) t_resp1 = t;
            end
            if (req_valid && req_ready) begin
                acc++;
                if (acc == 2) t_acc2 = t;
            end
            @(negedge clock);
            t++;
            if (acc == 1) begin
                req_write = 1'b0;
                req_wdata = $urandom;
            end else if (acc >= 2) begin
                req_valid = 1'b0;
            end
        end
        chk("b2b.accepts", acc, 32'd2);
        chk("b2b.responses", rcnt, 32'd2);
        chk("b2b.gap", t_acc2, t_resp1 + 1);
        chk("b2b.we_pulses", we_cnt - w0, 32'd1);
        if (rq.size() == 2) begin
            chk("b2b.store_rdata", rq[0], 32'd0);
            chk("b2b.load_rdata", rq[1], x);
        end else begin
            chk("b2b.queue", rq.size(), 32'd2);
        end
        ref_store(2'b10, 64, x);

        for (int i = 0; i < 200; i++) begin
            op("rnd", 1'($urandom), 2'($urandom), 1'($urandom),
               int'($urandom_range(0, 255)), $urandom, rd);
        end

        for (int i = 0; i < 64; i++) chk("final.mem", mem[i], ref_word(i));
        chk("addr_range", 32'(addr_oob), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
